irq_controller: RTL

IRQ_CONTROLLER -- requirements
Module: irq_controller

---
 rtl/irq_controller.sv | 136 +++++++++++++
 1 files changed

// File: rtl/irq_controller.sv
// 16-source interrupt controller: edge-detected pending bits, maskable, single-level service FSM, vector out.
// irq_in edge -> pending at edge k -> irq_req after k+1; no backpressure, and the request holds until irq_ack. Priority is set by IRQ_ROTATE_EN (round-robin) or fixed (lowest index).
module irq_controller #(
    parameter logic [11:0] VECTOR_BASE = 12'hF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] irq_in,
    input  logic        wr_en,
    input  logic [1:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        irq_ack,
    input  logic        irq_done,
    output logic        irq_req,
    output logic [11:0] vector,
    output logic [3:0]  active_id,
    output logic [15:0] pending,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] irq_in_q;
    logic [15:0] mask;
    logic        gie;
    logic [15:0] eligible;
    logic [15:0] rise;
    logic [15:0] clr;
    logic [15:0] pending_nxt;
    logic        any_elig;
    logic [3:0]  winner;
    logic        ctrl_wr;

`ifdef IRQ_ROTATE_EN
    logic [3:0]  rr_ptr;
`endif

    assign ctrl_wr     = wr_en && (wr_addr == 2'd2);
    assign eligible    = pending & mask & {16{gie}};
    assign any_elig    = |eligible;
    assign rise        = irq_in & ~irq_in_q;
    // New edges are OR-ed in after the clear so a same-cycle set always survives.
    assign pending_nxt = (pending & ~clr) | rise;

    always_comb begin
        clr = '0;
        if (state == REQ && irq_ack)
            clr[active_id] = 1'b1;
        if (ctrl_wr && wr_data[1])
            clr = '1;
    end

    // Walk from the highest offset down so the lowest offset from the start point wins.
    always_comb begin
        logic [3:0] idx;
        winner = '0;
        idx    = '0;
        for (int i = 15; i >= 0; i--) begin
`ifdef IRQ_ROTATE_EN
            idx = rr_ptr + 4'(i);
`else
            idx = 4'(i);
`endif
            if (eligible[idx])
                winner = idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            irq_in_q  <= '0;
            pending   <= '0;
            mask      <= '0;
            gie       <= 1'b0;
            active_id <= '0;
            irq_req   <= 1'b0;
            busy      <= 1'b0;
            vector    <= VECTOR_BASE;
`ifdef IRQ_ROTATE_EN
            rr_ptr    <= '0;
`endif
        end else begin
            irq_in_q <= irq_in;
            pending  <= pending_nxt;

            if (wr_en) begin
                case (wr_addr)
                    2'd0:    mask[7:0]  <= wr_data;
                    2'd1:    mask[15:8] <= wr_data;
                    2'd2:    gie        <= wr_data[0];
                    default: ;
                endcase
            end

            case (state)
                IDLE: begin
                    if (any_elig) begin
                        state     <= REQ;
                        active_id <= winner;
                        vector    <= VECTOR_BASE + {4'h0, winner, 4'h0};
                        irq_req   <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                REQ: begin
                    // A concurrent irq_done is meaningless until the handler has been entered.
                    if (irq_ack) begin
                        state   <= SERVICE;
                        irq_req <= 1'b0;
`ifdef IRQ_ROTATE_EN
                        rr_ptr  <= active_id + 4'd1;
`endif
                    end
                end
                SERVICE: begin
                    if (irq_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    irq_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
